// File: rtl/cache_pkg.sv
// Shared definitions for the cache port arbiter: FSM encoding, default widths
// and the WAIT-state timeout.
package cache_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CMD0,
      ST_CMD1,
      ST_WAIT,
      ST_RESP
   } state_t;

   localparam int DEF_NUM_REQ    = 4;
   localparam int DEF_DATA_WIDTH = 16;
   localparam int DEF_TAG_WIDTH  = 4;
   localparam int DEF_TIMEOUT    = 15;
   localparam int INDEX_WIDTH    = 6;
   localparam int CNT_WIDTH      = 4;

endpackage

// File: rtl/cache_port_arbiter_if.sv
// Requester-side and cache-side signals of the arbiter, bundled as one bus.
// The arbiter uses the slave view; the requester/cache environment uses master.
interface cache_port_arbiter_if
   import cache_pkg::*;
#(
   parameter int NUM_REQ    = DEF_NUM_REQ,
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int TAG_WIDTH  = DEF_TAG_WIDTH
);

   logic [NUM_REQ-1:0]             req;
   logic [NUM_REQ-1:0]             req_we;
   logic [NUM_REQ*TAG_WIDTH-1:0]   req_tag;
   logic [NUM_REQ*INDEX_WIDTH-1:0] req_index;
   logic [NUM_REQ*DATA_WIDTH-1:0]  req_wdata;
   logic [NUM_REQ-1:0]             gnt;
   logic [NUM_REQ-1:0]             done;
   logic [DATA_WIDTH-1:0]          rsp_data;
   logic                           rsp_hit;
   logic                           rsp_err;

   logic                           cache_read;
   logic                           cache_write;
   logic [TAG_WIDTH-1:0]           cache_tag;
   logic [INDEX_WIDTH-1:0]         cache_index;
   logic [DATA_WIDTH-1:0]          cache_wdata;
   logic [DATA_WIDTH-1:0]          cache_rdata;
   logic                           cache_hit;
   logic                           cache_ready;

   modport slave (
      input  req, req_we, req_tag, req_index, req_wdata,
      input  cache_rdata, cache_hit, cache_ready,
      output gnt, done, rsp_data, rsp_hit, rsp_err,
      output cache_read, cache_write, cache_tag, cache_index, cache_wdata
   );

   modport master (
      output req, req_we, req_tag, req_index, req_wdata,
      output cache_rdata, cache_hit, cache_ready,
      input  gnt, done, rsp_data, rsp_hit, rsp_err,
      input  cache_read, cache_write, cache_tag, cache_index, cache_wdata
   );

endinterface

// File: rtl/cache_port_arbiter_rr_picker.sv
// Combinational round-robin picker: one-hot grant of the first active request
// found when scanning upward from the slot after ptr, wrapping at NUM_REQ.
module rr_picker #(
   parameter int NUM_REQ = 4,
   parameter int PTR_W   = 2
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [PTR_W-1:0]   ptr,
   output logic [NUM_REQ-1:0] gnt
);

   int idx;

   // Scan farthest-first so the nearest active slot after ptr is written last.
   always_comb begin
      gnt = '0;
      idx = 0;
      for (int k = NUM_REQ; k >= 1; k--) begin
         idx = (int'(ptr) + k) % NUM_REQ;
         if (req[idx]) begin
            gnt = '0;
            gnt[idx] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/cache_port_arbiter.sv
// Shares one cache port among NUM_REQ requesters: round-robin grant, a
// two-cycle cache command, bounded wait for the cache, then a done pulse.
module cache_port_arbiter
   import cache_pkg::*;
#(
   parameter int NUM_REQ    = DEF_NUM_REQ,
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int TAG_WIDTH  = DEF_TAG_WIDTH,
   parameter int TIMEOUT    = DEF_TIMEOUT
) (
   input logic                 clk,
   input logic                 rst,
   cache_port_arbiter_if.slave bus
);

   localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   state_t               state;
   state_t               state_nxt;
   logic [PTR_W-1:0]     ptr;
   logic [PTR_W-1:0]     cur_idx;
   logic [PTR_W-1:0]     win_idx;
   logic [NUM_REQ-1:0]   pick;
   logic [CNT_WIDTH-1:0] cnt;
   logic                 we_q;
   logic                 hit_q;
   logic                 timeout_hit;

   rr_picker #(
      .NUM_REQ (NUM_REQ),
      .PTR_W   (PTR_W)
   ) u_picker (
      .req (bus.req),
      .ptr (ptr),
      .gnt (pick)
   );

   always_comb begin
      win_idx = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (pick[i]) win_idx = PTR_W'(i);
      end
   end

   // Counter runs 0..TIMEOUT-1 in WAIT, so WAIT lasts exactly TIMEOUT cycles.
   assign timeout_hit = (cnt == CNT_WIDTH'(TIMEOUT - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (|bus.req) state_nxt = ST_CMD0;
         ST_CMD0: state_nxt = ST_CMD1;
         ST_CMD1: state_nxt = ST_WAIT;
         ST_WAIT: if (bus.cache_ready || timeout_hit) state_nxt = ST_RESP;
         ST_RESP: state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bus.gnt         <= '0;
         bus.done        <= '0;
         bus.rsp_data    <= '0;
         bus.rsp_hit     <= 1'b0;
         bus.rsp_err     <= 1'b0;
         bus.cache_read  <= 1'b0;
         bus.cache_write <= 1'b0;
         bus.cache_tag   <= '0;
         bus.cache_index <= '0;
         bus.cache_wdata <= '0;
         ptr             <= PTR_W'(NUM_REQ - 1);
         cur_idx         <= '0;
         cnt             <= '0;
         we_q            <= 1'b0;
         hit_q           <= 1'b0;
      end else begin
         bus.done <= '0;
         case (state)
            ST_IDLE: begin
               if (|bus.req) begin
                  bus.gnt         <= pick;
                  cur_idx         <= win_idx;
                  we_q            <= bus.req_we[win_idx];
                  bus.cache_read  <= ~bus.req_we[win_idx];
                  bus.cache_write <= bus.req_we[win_idx];
                  bus.cache_tag   <= bus.req_tag[win_idx*TAG_WIDTH +: TAG_WIDTH];
                  bus.cache_index <= bus.req_index[win_idx*INDEX_WIDTH +: INDEX_WIDTH];
                  bus.cache_wdata <= bus.req_wdata[win_idx*DATA_WIDTH +: DATA_WIDTH];
                  cnt             <= '0;
               end
            end
            ST_CMD1: begin
               hit_q           <= bus.cache_hit;
               bus.cache_read  <= 1'b0;
               bus.cache_write <= 1'b0;
            end
            ST_WAIT: begin
               if (bus.cache_ready || timeout_hit) begin
                  bus.done        <= bus.gnt;
                  bus.rsp_err     <= ~bus.cache_ready;
                  bus.rsp_data    <= (bus.cache_ready && !we_q) ? bus.cache_rdata : '0;
                  bus.rsp_hit     <= hit_q & ~we_q;
                  bus.cache_tag   <= '0;
                  bus.cache_index <= '0;
                  bus.cache_wdata <= '0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            ST_RESP: begin
               bus.gnt      <= '0;
               ptr          <= cur_idx;
               bus.rsp_data <= '0;
               bus.rsp_hit  <= 1'b0;
               bus.rsp_err  <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule
